// File: rtl/mult_pkg.sv
`default_nettype none
//==============================================================================
// Module      : mult_pkg
// Description : Shared types and helpers for the pipelined integer multiplier.
// Revision    : 1.0 - initial release
//==============================================================================
package mult_pkg;

    localparam int unsigned c_def_xlen  = 64;
    localparam int unsigned c_def_tag_w = 6;

    typedef enum logic [1:0] {
        MUL_LO  = 2'b00,
        MUL_HU  = 2'b01,
        MUL_HS  = 2'b10,
        MUL_HSU = 2'b11
    } mult_func_e;

    // Payload of one stage at the default configuration.
    typedef struct packed {
        logic                     valid;
        logic [c_def_tag_w-1:0]   tag;
        mult_func_e               func;
        logic [2*c_def_xlen-1:0]  product;
        logic [2*c_def_xlen-1:0]  mplier;
        logic [2*c_def_xlen-1:0]  mcand;
    } mult_stage_t;

    function automatic logic op_a_signed(input mult_func_e f);
        return (f == MUL_HS) || (f == MUL_HSU);
    endfunction

    function automatic logic op_b_signed(input mult_func_e f);
        return (f == MUL_HS);
    endfunction

endpackage : mult_pkg
`default_nettype wire

// File: rtl/pipe_mult_stage.sv
`default_nettype none
//==============================================================================
// Module      : pipe_mult_stage
// Description : One radix-2^CHUNK step of the multiplier pipeline.
// Revision    : 1.0 - initial release
//==============================================================================
module pipe_mult_stage
    import mult_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter int CHUNK = 16,
    parameter int TAG_W = 6
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              en,
    input  logic              kill,
    input  logic              i_valid,
    input  logic [TAG_W-1:0]  i_tag,
    input  mult_func_e        i_func,
    input  logic [2*XLEN-1:0] i_product,
    input  logic [2*XLEN-1:0] i_mplier,
    input  logic [2*XLEN-1:0] i_mcand,
    output logic              o_valid,
    output logic [TAG_W-1:0]  o_tag,
    output mult_func_e        o_func,
    output logic [2*XLEN-1:0] o_product,
    output logic [2*XLEN-1:0] o_mplier,
    output logic [2*XLEN-1:0] o_mcand
);

    localparam int c_pw = 2 * XLEN;

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        mult_func_e       func;
        logic [c_pw-1:0]  product;
        logic [c_pw-1:0]  mplier;
        logic [c_pw-1:0]  mcand;
    } stage_t;

    stage_t          r_stage;
    stage_t          w_next;
    logic [c_pw-1:0] w_chunk;

    always_comb begin
        w_chunk              = '0;
        w_chunk[CHUNK-1:0]   = i_mplier[CHUNK-1:0];
        w_next.valid         = i_valid;
        w_next.tag           = i_tag;
        w_next.func          = i_func;
        w_next.product       = i_product + (w_chunk * i_mcand);
        w_next.mplier        = i_mplier >> CHUNK;
        w_next.mcand         = i_mcand << CHUNK;
    end

    // Kill only clears the valid bit; the stale payload is harmless.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_stage <= '0;
        end else if (kill) begin
            r_stage.valid <= 1'b0;
        end else if (en) begin
            r_stage <= w_next;
        end
    end

    assign o_valid   = r_stage.valid;
    assign o_tag     = r_stage.tag;
    assign o_func    = r_stage.func;
    assign o_product = r_stage.product;
    assign o_mplier  = r_stage.mplier;
    assign o_mcand   = r_stage.mcand;

endmodule : pipe_mult_stage
`default_nettype wire

// File: rtl/pipe_mult.sv
`default_nettype none
//==============================================================================
// Module      : pipe_mult
// Description : Pipelined signed/unsigned/mixed multiplier with valid/ready,
//               global squash and tag passthrough.
// Revision    : 1.0 - initial release
//==============================================================================
module pipe_mult
    import mult_pkg::*;
#(
    parameter int XLEN       = c_def_xlen,
    parameter int NUM_STAGES = 8,
    parameter int TAG_W      = c_def_tag_w
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             valid_in,
    output logic             ready_out,
    input  logic [XLEN-1:0]  opa,
    input  logic [XLEN-1:0]  opb,
    input  logic [1:0]       func,
    input  logic [TAG_W-1:0] tag_in,
    input  logic             flush,
    output logic             valid_out,
    input  logic             ready_in,
    output logic [XLEN-1:0]  result,
    output logic [TAG_W-1:0] tag_out
);

    localparam int c_pw    = 2 * XLEN;
    localparam int c_chunk = c_pw / NUM_STAGES;

    mult_func_e      w_func;
    logic            w_stall;

    // Element 0 is the conditioned entry; element i+1 is stage i's register.
    logic             w_valid   [NUM_STAGES+1];
    logic [TAG_W-1:0] w_tag     [NUM_STAGES+1];
    mult_func_e       w_fn      [NUM_STAGES+1];
    logic [c_pw-1:0]  w_product [NUM_STAGES+1];
    logic [c_pw-1:0]  w_mplier  [NUM_STAGES+1];
    logic [c_pw-1:0]  w_mcand   [NUM_STAGES+1];

    assign w_func = mult_func_e'(func);

    // A stalled pipe does not load stage 0, so ready_out needs no extra gating here.
    assign w_valid[0]   = valid_in & ~flush;
    assign w_tag[0]     = tag_in;
    assign w_fn[0]      = w_func;
    assign w_product[0] = '0;
    assign w_mcand[0]   = op_a_signed(w_func) ? {{XLEN{opa[XLEN-1]}}, opa}
                                              : {{XLEN{1'b0}}, opa};
    assign w_mplier[0]  = op_b_signed(w_func) ? {{XLEN{opb[XLEN-1]}}, opb}
                                              : {{XLEN{1'b0}}, opb};

    generate
        for (genvar g_i = 0; g_i < NUM_STAGES; g_i++) begin : g_stage
            pipe_mult_stage #(
                .XLEN  (XLEN),
                .CHUNK (c_chunk),
                .TAG_W (TAG_W)
            ) u_stage (
                .clock     (clock),
                .reset     (reset),
                .en        (~w_stall),
                .kill      (flush),
                .i_valid   (w_valid[g_i]),
                .i_tag     (w_tag[g_i]),
                .i_func    (w_fn[g_i]),
                .i_product (w_product[g_i]),
                .i_mplier  (w_mplier[g_i]),
                .i_mcand   (w_mcand[g_i]),
                .o_valid   (w_valid[g_i+1]),
                .o_tag     (w_tag[g_i+1]),
                .o_func    (w_fn[g_i+1]),
                .o_product (w_product[g_i+1]),
                .o_mplier  (w_mplier[g_i+1]),
                .o_mcand   (w_mcand[g_i+1])
            );
        end
    endgenerate

    assign valid_out = w_valid[NUM_STAGES];
    assign tag_out   = w_tag[NUM_STAGES];
    assign w_stall   = valid_out & ~ready_in;
    assign ready_out = ~w_stall;

    always_comb begin
        result = w_product[NUM_STAGES][c_pw-1:XLEN];
        if (w_fn[NUM_STAGES] == MUL_LO) begin
            result = w_product[NUM_STAGES][XLEN-1:0];
        end
    end

endmodule : pipe_mult
`default_nettype wire

// File: tb/tb_pipe_mult.sv
`default_nettype none
//==============================================================================
// Module      : tb_pipe_mult
// Description : Self-checking bench for pipe_mult (64b/8-stage and 32b/4-stage).
// Revision    : 1.0 - initial release
//==============================================================================
module tb_pipe_mult;

    localparam int c_xl_b = 64;
    localparam int c_ns_b = 8;
    localparam int c_xl_s = 32;
    localparam int c_ns_s = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic        valid_in;
    logic        ready_in;
    logic        flush;
    logic [63:0] opa;
    logic [63:0] opb;
    logic [1:0]  func;
    logic [5:0]  tag_in;

    logic        b_ready_out, b_valid_out;
    logic [63:0] b_result;
    logic [5:0]  b_tag_out;
    logic        s_ready_out, s_valid_out;
    logic [31:0] s_result;
    logic [5:0]  s_tag_out;

    int checks   = 0;
    int failures = 0;
    bit use_small = 1'b0;

    always #5 clock = ~clock;

    pipe_mult #(.XLEN(c_xl_b), .NUM_STAGES(c_ns_b), .TAG_W(6)) u_big (
        .clock     (clock),
        .reset     (reset),
        .valid_in  (valid_in),
        .ready_out (b_ready_out),
        .opa       (opa),
        .opb       (opb),
        .func      (func),
        .tag_in    (tag_in),
        .flush     (flush),
        .valid_out (b_valid_out),
        .ready_in  (ready_in),
        .result    (b_result),
        .tag_out   (b_tag_out)
    );

    pipe_mult #(.XLEN(c_xl_s), .NUM_STAGES(c_ns_s), .TAG_W(6)) u_small (
        .clock     (clock),
        .reset     (reset),
        .valid_in  (valid_in),
        .ready_out (s_ready_out),
        .opa       (opa[31:0]),
        .opb       (opb[31:0]),
        .func      (func),
        .tag_in    (tag_in),
        .flush     (flush),
        .valid_out (s_valid_out),
        .ready_in  (ready_in),
        .result    (s_result),
        .tag_out   (s_tag_out)
    );

    function automatic logic obs_vout();
        return use_small ? s_valid_out : b_valid_out;
    endfunction
    function automatic logic obs_rdy();
        return use_small ? s_ready_out : b_ready_out;
    endfunction
    function automatic logic [63:0] obs_result();
        return use_small ? {32'd0, s_result} : b_result;
    endfunction
    function automatic logic [63:0] obs_tag();
        return {58'd0, (use_small ? s_tag_out : b_tag_out)};
    endfunction
    function automatic int cur_ns();
        return use_small ? c_ns_s : c_ns_b;
    endfunction

    // Exact product from the mathematical operand values, then half select.
    function automatic logic [63:0] ref_mul(input int xl, input logic [63:0] a,
                                            input logic [63:0] b, input logic [1:0] f);
        logic signed [129:0] av, bv, pr;
        logic [63:0] mask;
        mask = (xl == 64) ? {64{1'b1}} : ((64'd1 << xl) - 64'd1);
        av = {66'd0, a & mask};
        bv = {66'd0, b & mask};
        if ((f == 2'b10 || f == 2'b11) && a[xl-1]) av = av - (130'sd1 <<< xl);
        if (f == 2'b10 && b[xl-1]) bv = bv - (130'sd1 <<< xl);
        pr = av * bv;
        if (f != 2'b00) pr = pr >>> xl;
        return pr[63:0] & mask;
    endfunction

    function automatic logic [63:0] pick_operand();
        case ($urandom_range(0, 5))
            0: return {64{1'b1}};
            1: return 64'h8000_0000_8000_0000;
            2: return 64'd0;
            default: return {$urandom, $urandom};
        endcase
    endfunction

    task automatic chk(input string nm, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", nm, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clock);
        #1;
    endtask

    task automatic quiet(input string nm, input int n);
        bit seen;
        seen = 1'b0;
        repeat (n) begin
            if (obs_vout()) seen = 1'b1;
            step();
        end
        chk(nm, 64'(seen), 64'd0);
    endtask

    task automatic directed(input string nm, input logic [63:0] a, input logic [63:0] b,
                            input logic [1:0] f, input logic [5:0] t, input logic [63:0] exp);
        bit early;
        early = 1'b0;
        ready_in = 1'b1; flush = 1'b0;
        valid_in = 1'b1; opa = a; opb = b; func = f; tag_in = t;
        step();
        valid_in = 1'b0;
        for (int k = 0; k < cur_ns() - 1; k++) begin
            if (obs_vout()) early = 1'b1;
            step();
        end
        chk({nm, "_early"},  64'(early), 64'd0);
        chk({nm, "_valid"},  64'(obs_vout()), 64'd1);
        chk({nm, "_result"}, obs_result(), exp);
        chk({nm, "_tag"},    obs_tag(), {58'd0, t});
        step();
    endtask

    task automatic random_stream(input string nm, input int nops);
        logic [63:0] q_res [$];
        logic [5:0]  q_tag [$];
        int sent, got, cyc, xl;
        sent = 0; got = 0; cyc = 0;
        xl = use_small ? c_xl_s : c_xl_b;
        flush = 1'b0;
        while ((sent < nops || got < nops) && cyc < 800) begin
            ready_in = ($urandom_range(0, 2) != 0);
            valid_in = (sent < nops) && ($urandom_range(0, 3) != 0);
            opa      = pick_operand();
            opb      = pick_operand();
            func     = 2'($urandom_range(0, 3));
            tag_in   = 6'($urandom_range(0, 63));
            #1;
            if (obs_vout()) begin
                if (q_res.size() == 0) begin
                    chk({nm, "_spurious"}, 64'(obs_vout()), 64'd0);
                end else begin
                    chk({nm, "_result"}, obs_result(), q_res[0]);
                    chk({nm, "_tag"}, obs_tag(), {58'd0, q_tag[0]});
                    if (ready_in) begin
                        void'(q_res.pop_front());
                        void'(q_tag.pop_front());
                        got++;
                    end
                end
            end
            if (valid_in && obs_rdy()) begin
                q_res.push_back(ref_mul(xl, opa, opb, func));
                q_tag.push_back(tag_in);
                sent++;
            end
            step();
            cyc++;
        end
        valid_in = 1'b0;
        ready_in = 1'b1;
        chk({nm, "_delivered"}, 64'(got), 64'(nops));
        quiet({nm, "_drain"}, cur_ns() + 2);
    endtask

    task automatic fill_stalled(input string nm);
        ready_in = 1'b0; flush = 1'b0;
        for (int i = 0; i < cur_ns() + 3; i++) begin
            valid_in = 1'b1;
            opa = pick_operand(); opb = pick_operand();
            func = 2'($urandom_range(0, 3));
            tag_in = 6'($urandom_range(1, 63));
            step();
        end
        valid_in = 1'b0;
        #1;
        chk({nm, "_stalled_valid"}, 64'(obs_vout()), 64'd1);
        chk({nm, "_stalled_ready"}, 64'(obs_rdy()), 64'd0);
    endtask

    task automatic reset_midstream(input string nm);
        fill_stalled(nm);
        reset = 1'b1;
        step();
        chk({nm, "_rst_valid"},  64'(obs_vout()), 64'd0);
        chk({nm, "_rst_result"}, obs_result(), 64'd0);
        chk({nm, "_rst_tag"},    obs_tag(), 64'd0);
        reset = 1'b0;
        ready_in = 1'b1;
        step();
        chk({nm, "_rst_ready"}, 64'(obs_rdy()), 64'd1);
        quiet({nm, "_rst_quiet"}, 2 * cur_ns() + 2);
    endtask

    initial begin
        reset = 1'b1; valid_in = 1'b0; ready_in = 1'b1; flush = 1'b0;
        opa = '0; opb = '0; func = 2'b00; tag_in = '0;
        step();
        chk("rst_valid",  64'(b_valid_out), 64'd0);
        chk("rst_result", b_result, 64'd0);
        chk("rst_tag",    {58'd0, b_tag_out}, 64'd0);
        step();
        reset = 1'b0;
        step();
        for (int i = 0; i < 20; i++) begin
            chk("idle_valid",  64'(b_valid_out), 64'd0);
            chk("idle_result", b_result, 64'd0);
            chk("idle_ready",  64'(b_ready_out), 64'd1);
            step();
        end

        directed("mul_7x6",    64'd7, 64'd6, 2'b00, 6'd5, 64'd42);
        directed("mulhu_max2", 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 2'b01, 6'd17, 64'd1);
        directed("mulh_m1m1",  64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 2'b10, 6'd1, 64'd0);
        directed("mulh_m2x3",  64'hFFFF_FFFF_FFFF_FFFE, 64'd3, 2'b10, 6'd2, 64'hFFFF_FFFF_FFFF_FFFF);
        directed("mulhsu_m1x2", 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 2'b11, 6'd3, 64'hFFFF_FFFF_FFFF_FFFF);
        directed("mul_m3x5",   64'hFFFF_FFFF_FFFF_FFFD, 64'd5, 2'b00, 6'd4, 64'hFFFF_FFFF_FFFF_FFF1);

        random_stream("b_rand", 16);

        // Squash five in-flight ops together with a same-cycle request.
        ready_in = 1'b1;
        for (int i = 0; i < 5; i++) begin
            valid_in = 1'b1; opa = pick_operand(); opb = pick_operand();
            func = 2'($urandom_range(0, 3)); tag_in = 6'(i + 10);
            step();
        end
        flush = 1'b1; valid_in = 1'b1; opa = 64'd9; opb = 64'd9; func = 2'b00;
        step();
        flush = 1'b0; valid_in = 1'b0;
        quiet("flush_quiet", 10);
        directed("mul_3x3", 64'd3, 64'd3, 2'b00, 6'd9, 64'd9);

        fill_stalled("fs");
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("fs_drop_valid", 64'(b_valid_out), 64'd0);
        chk("fs_ready",      64'(b_ready_out), 64'd1);
        ready_in = 1'b1;
        quiet("fs_quiet", c_ns_b + 2);

        reset_midstream("b");
        directed("b_post_reset", 64'd7, 64'd6, 2'b00, 6'd5, 64'd42);

        use_small = 1'b1;
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
        chk("s_idle_valid", 64'(s_valid_out), 64'd0);
        chk("s_idle_ready", 64'(s_ready_out), 64'd1);
        directed("s_mul_7x6",   64'd7, 64'd6, 2'b00, 6'd5, 64'd42);
        directed("s_mulh_m2x3", 64'h0000_0000_FFFF_FFFE, 64'd3, 2'b10, 6'd6, 64'h0000_0000_FFFF_FFFF);
        directed("s_mulhu_max2", 64'h0000_0000_FFFF_FFFF, 64'd2, 2'b01, 6'd7, 64'd1);
        random_stream("s_rand", 16);
        reset_midstream("s");
        random_stream("s_rand2", 8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_pipe_mult
`default_nettype wire
